// File: rtl/mag_comp_serial.sv
// mag_comp_serial: bit-serial MSB-first unsigned magnitude comparator with start/busy/done handshake.
// Define CMP_EARLY_EXIT_EN to finish on the first differing bit instead of after all WIDTH bits.
module mag_comp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             M
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic lt, gt, nlt, ngt, last, fin, load;
  assign nlt  = lt | (~gt & ~sa[WIDTH-1] & sb[WIDTH-1]);
  assign ngt  = gt | (~lt & sa[WIDTH-1] & ~sb[WIDTH-1]);
  assign last = cnt == CW'(WIDTH - 1);
`ifdef CMP_EARLY_EXIT_EN
  assign fin  = last | nlt | ngt;
`else
  assign fin  = last;
`endif
  assign load = start & (state != CMP);
  assign busy = state == CMP;
  assign done = state == DONE;
  always_comb begin
    state_nx = IDLE;
    state_nx = load ? CMP : (state == CMP) ? (fin ? DONE : CMP) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      L     <= 1'b0;
      E     <= 1'b0;
      M     <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        sa  <= a;
        sb  <= b;
        cnt <= '0;
        lt  <= 1'b0;
        gt  <= 1'b0;
        L   <= 1'b0;
        E   <= 1'b0;
        M   <= 1'b0;
      end else if (state == CMP) begin
        sa  <= sa << 1;
        sb  <= sb << 1;
        cnt <= cnt + 1'b1;
        lt  <= nlt;
        gt  <= ngt;
        if (fin) begin
          L <= nlt;
          M <= ngt;
          E <= ~(nlt | ngt);
        end
      end
    end
  end
endmodule

// File: tb/tb_mag_comp_serial.sv
// tb_mag_comp_serial: scoreboard bench for mag_comp_serial at WIDTH 8, 2 and 64.
module tb_mag_comp_serial;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef struct {logic [2:0] lem; int due;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s8 = 1'b0, s2 = 1'b0, s64 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] a2 = '0, b2 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  logic busy8, done8, l8, e8, m8;
  logic busy2, done2, l2, e2, m2;
  logic busy64, done64, l64, e64, m64;
  int cyc = 0, total = 0, bad = 0;
  exp_t q8[$], q2[$], q64[$];
  exp_t x8, x2, x64;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mag_comp_serial #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .L(l8), .E(e8), .M(m8));
  mag_comp_serial #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .L(l2), .E(e2), .M(m2));
  mag_comp_serial #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .start(s64), .a(a64), .b(b64),
    .busy(busy64), .done(done64), .L(l64), .E(e64), .M(m64));
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, got, want, cyc);
    end
  endtask
  function automatic logic [2:0] lem_of(input logic [63:0] x, input logic [63:0] y);
    return x < y ? 3'b100 : x == y ? 3'b010 : 3'b001;
  endfunction
  function automatic int lat_of(input logic [63:0] x, input logic [63:0] y, input int w);
    int k = w;
    for (int i = 0; i < w; i++) if (x[w-1-i] !== y[w-1-i]) begin k = i + 1; break; end
    return EARLY ? k : w;
  endfunction
  // monitors: every done must match the oldest outstanding expectation, including its cycle
  always @(negedge clk) if (done8) begin
    if (q8.size() == 0) chk("u8_unexpected_done", {l8, e8, m8}, 3'b000);
    else begin
      x8 = q8.pop_front();
      chk("u8_lem", {l8, e8, m8}, x8.lem);
      chk("u8_latency", cyc, x8.due);
      chk("u8_busy_at_done", busy8, 1'b0);
    end
  end
  always @(negedge clk) if (done2) begin
    if (q2.size() == 0) chk("u2_unexpected_done", {l2, e2, m2}, 3'b000);
    else begin
      x2 = q2.pop_front();
      chk("u2_lem", {l2, e2, m2}, x2.lem);
      chk("u2_latency", cyc, x2.due);
    end
  end
  always @(negedge clk) if (done64) begin
    if (q64.size() == 0) chk("u64_unexpected_done", {l64, e64, m64}, 3'b000);
    else begin
      x64 = q64.pop_front();
      chk("u64_lem", {l64, e64, m64}, x64.lem);
      chk("u64_latency", cyc, x64.due);
    end
  end
  task automatic run8(input logic [7:0] x, input logic [7:0] y);
    int lat = lat_of(64'(x), 64'(y), 8);
    @(negedge clk);
    a8 = x; b8 = y; s8 = 1'b1;
    q8.push_back('{lem_of(64'(x), 64'(y)), cyc + 1 + lat});
    @(negedge clk);
    s8 = 1'b0;
    repeat (lat) @(negedge clk);
  endtask
  task automatic run2(input logic [1:0] x, input logic [1:0] y);
    int lat = lat_of(64'(x), 64'(y), 2);
    @(negedge clk);
    a2 = x; b2 = y; s2 = 1'b1;
    q2.push_back('{lem_of(64'(x), 64'(y)), cyc + 1 + lat});
    @(negedge clk);
    s2 = 1'b0;
    repeat (lat) @(negedge clk);
  endtask
  task automatic run64(input logic [63:0] x, input logic [63:0] y);
    int lat = lat_of(x, y, 64);
    @(negedge clk);
    a64 = x; b64 = y; s64 = 1'b1;
    q64.push_back('{lem_of(x, y), cyc + 1 + lat});
    @(negedge clk);
    s64 = 1'b0;
    repeat (lat) @(negedge clk);
  endtask
  initial begin
    int due1, lat2;
    logic [63:0] x, y;
    repeat (2) @(negedge clk);
    chk("reset_busy_done", {busy8, done8}, 2'b00);
    chk("reset_lem", {l8, e8, m8}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h5B; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    chk("mid_busy_before_reset", busy8, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset_busy_done", {busy8, done8}, 2'b00);
    chk("mid_reset_lem", {l8, e8, m8}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_reset_idle", busy8, 1'b0);
    run8(8'h5A, 8'h5B);
    run8(8'h80, 8'h7F);
    run8(8'h3C, 8'h3C);
    run8(8'h01, 8'h00);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
    q8.push_back('{3'b010, cyc + 9});
    @(negedge clk);
    s8 = 1'b0;
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    @(negedge clk);
    s8 = 1'b0; a8 = 8'h12; b8 = 8'hF0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_lem", {l8, e8, m8, done8}, 4'b0100);
    end
    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; s8 = 1'b1;
    due1 = cyc + 1 + lat_of(64'h00, 64'hFF, 8);
    q8.push_back('{3'b100, due1});
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00;
    while (cyc < due1) @(negedge clk);
    lat2 = lat_of(64'hFF, 64'h00, 8);
    q8.push_back('{3'b001, due1 + 1 + lat2});
    @(negedge clk);
    chk("b2b_busy_after_done", busy8, 1'b1);
    s8 = 1'b0;
    repeat (lat2 + 2) @(negedge clk);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) run2(2'(i), 2'(j));
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      y = (i % 4 == 0) ? x ^ (64'd1 << $urandom_range(63, 0)) : (i % 50 == 0) ? x : {$urandom, $urandom};
      run64(x, y);
    end
    repeat (4) @(negedge clk);
    chk("u8_pending", 64'(q8.size()), 64'd0);
    chk("u2_pending", 64'(q2.size()), 64'd0);
    chk("u64_pending", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  // every done must carry exactly one of L/E/M
  always @(negedge clk) begin
    if (done8) chk("u8_onehot", 64'($countones({l8, e8, m8})), 64'd1);
    if (done2) chk("u2_onehot", 64'($countones({l2, e2, m2})), 64'd1);
    if (done64) chk("u64_onehot", 64'($countones({l64, e64, m64})), 64'd1);
  end
endmodule
